// File: rtl/sdram_arbiter.sv
// Round-robin arbiter granting three audio clients single-word access to one
// Avalon-MM SDRAM slave, returning a one-cycle finished pulse per transaction.
module sdram_arbiter (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [2:0]  c_read,
   input  logic [2:0]  c_write,
   input  logic [68:0] c_addr,
   input  logic [47:0] c_writedata,
   output logic [15:0] c_readdata,
   output logic [2:0]  c_read_finished,
   output logic [2:0]  c_write_finished,
   output logic [22:0] sdram_addr,
   output logic        sdram_read,
   output logic        sdram_write,
   output logic [15:0] sdram_writedata,
   input  logic [15:0] sdram_readdata,
   input  logic        sdram_waitrequest,
   input  logic        sdram_readdatavalid
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, DONE} state_t;

   state_t      state, state_nxt;
   logic [1:0]  grant, last_grant;
   logic        op_rd;
   logic [22:0] addr_q;
   logic [15:0] wdata_q;

   logic [2:0]  req;
   logic [22:0] addr_arr  [3];
   logic [15:0] wdata_arr [3];
   logic [1:0]  pick;
   logic        pick_found;
   logic [1:0]  cand;
   logic        accept;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   assign req = c_read | c_write;

   assign addr_arr[0]  = c_addr[22:0];
   assign addr_arr[1]  = c_addr[45:23];
   assign addr_arr[2]  = c_addr[68:46];
   assign wdata_arr[0] = c_writedata[15:0];
   assign wdata_arr[1] = c_writedata[31:16];
   assign wdata_arr[2] = c_writedata[47:32];

   // Search starts one past the previous grant so no client is granted twice
   // while another is waiting.
   always_comb begin
      pick       = 2'd0;
      pick_found = 1'b0;
      cand       = next_idx(last_grant);
      for (int k = 0; k < 3; k++) begin
         if (!pick_found && req[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
         cand = next_idx(cand);
      end
   end

   assign accept = (state == ISSUE) && !sdram_waitrequest;

   always_comb begin
      state_nxt        = state;
      sdram_read       = 1'b0;
      sdram_write      = 1'b0;
      sdram_addr       = addr_q;
      sdram_writedata  = wdata_q;
      c_read_finished  = 3'b000;
      c_write_finished = 3'b000;
      case (state)
         IDLE: begin
            if (pick_found) state_nxt = ISSUE;
         end
         ISSUE: begin
            sdram_read  = op_rd;
            sdram_write = !op_rd;
            if (accept) state_nxt = op_rd ? WAIT_DATA : DONE;
         end
         WAIT_DATA: begin
            if (sdram_readdatavalid) state_nxt = DONE;
         end
         DONE: begin
            if (op_rd) c_read_finished  = 3'b001 << grant;
            else       c_write_finished = 3'b001 << grant;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         grant      <= 2'd0;
         last_grant <= 2'd2;
         op_rd      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         c_readdata <= '0;
      end else begin
         state <= state_nxt;
         // Request lines are only sampled here; later changes are ignored.
         if (state == IDLE && pick_found) begin
            grant      <= pick;
            last_grant <= pick;
            op_rd      <= c_read[pick];
            addr_q     <= addr_arr[pick];
            wdata_q    <= wdata_arr[pick];
         end
         if (state == WAIT_DATA && sdram_readdatavalid)
            c_readdata <= sdram_readdata;
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: single write/read, stall, round robin,
// read+write priority, stray readdatavalid and mid-transaction reset.
module tb_sdram_arbiter;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [2:0]  c_read, c_write;
   logic [68:0] c_addr;
   logic [47:0] c_writedata;
   logic [15:0] c_readdata;
   logic [2:0]  c_read_finished, c_write_finished;
   logic [22:0] sdram_addr;
   logic        sdram_read, sdram_write;
   logic [15:0] sdram_writedata;
   logic [15:0] sdram_readdata;
   logic        sdram_waitrequest, sdram_readdatavalid;

   int n_cmp = 0;
   int n_err = 0;

   sdram_arbiter dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .c_read(c_read), .c_write(c_write),
      .c_addr(c_addr), .c_writedata(c_writedata),
      .c_readdata(c_readdata),
      .c_read_finished(c_read_finished), .c_write_finished(c_write_finished),
      .sdram_addr(sdram_addr), .sdram_read(sdram_read), .sdram_write(sdram_write),
      .sdram_writedata(sdram_writedata), .sdram_readdata(sdram_readdata),
      .sdram_waitrequest(sdram_waitrequest), .sdram_readdatavalid(sdram_readdatavalid)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_rd"}, {31'd0, sdram_read}, 32'd0);
      chk({tag, "_wr"}, {31'd0, sdram_write}, 32'd0);
      chk({tag, "_fin"}, {26'd0, c_read_finished, c_write_finished}, 32'd0);
   endtask

   initial begin
      logic [2:0] rr_exp [6];
      rr_exp = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

      i_rst = 1'b1;
      c_read = '0; c_write = '0; c_addr = '0; c_writedata = '0;
      sdram_readdata = '0; sdram_waitrequest = 1'b0; sdram_readdatavalid = 1'b0;
      tick(); tick();
      i_rst = 1'b0;
      tick();
      chk_idle_outs("reset");
      chk("reset_addr", {9'd0, sdram_addr}, 32'd0);
      chk("reset_wdata", {16'd0, sdram_writedata}, 32'd0);
      chk("reset_rdata", {16'd0, c_readdata}, 32'd0);

      // Single write from client 2
      c_write = 3'b100; c_addr[68:46] = 23'h000010; c_writedata[47:32] = 16'hBEEF;
      tick();
      chk("wr_cmd", {30'd0, sdram_write, sdram_read}, 32'b10);
      chk("wr_addr", {9'd0, sdram_addr}, 32'h10);
      chk("wr_data", {16'd0, sdram_writedata}, 32'hBEEF);
      chk("wr_fin_early", {29'd0, c_write_finished}, 32'd0);
      tick();
      chk("wr_fin", {26'd0, c_read_finished, c_write_finished}, 32'b000_100);
      chk("wr_cmd_off", {31'd0, sdram_write}, 32'd0);
      c_write = 3'b000;
      tick();
      chk_idle_outs("wr_after");

      // Single read from client 0, latency 3
      c_read = 3'b001; c_addr[22:0] = 23'h7FFFFF;
      tick();
      chk("rd_cmd", {30'd0, sdram_write, sdram_read}, 32'b01);
      chk("rd_addr", {9'd0, sdram_addr}, 32'h7FFFFF);
      tick();
      chk("rd_wait1", {26'd0, c_read_finished, c_write_finished}, 32'd0);
      chk("rd_cmd_off", {31'd0, sdram_read}, 32'd0);
      tick();
      chk("rd_wait2", {29'd0, c_read_finished}, 32'd0);
      tick();
      sdram_readdatavalid = 1'b1; sdram_readdata = 16'h1234;
      tick();
      chk("rd_fin", {26'd0, c_read_finished, c_write_finished}, 32'b001_000);
      chk("rd_data", {16'd0, c_readdata}, 32'h1234);
      c_read = 3'b000; sdram_readdatavalid = 1'b0; sdram_readdata = 16'h0000;
      tick();
      chk_idle_outs("rd_after");
      chk("rd_data_hold", {16'd0, c_readdata}, 32'h1234);

      // Waitrequest stall: write from client 1, four stall cycles
      c_write = 3'b010; c_addr[45:23] = 23'h2AAAAA; c_writedata[31:16] = 16'h5A5A;
      sdram_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_cmd", {30'd0, sdram_write, sdram_read}, 32'b10);
         chk("stall_addr", {9'd0, sdram_addr}, 32'h2AAAAA);
         chk("stall_data", {16'd0, sdram_writedata}, 32'h5A5A);
         chk("stall_fin", {29'd0, c_write_finished}, 32'd0);
         if (i == 4) sdram_waitrequest = 1'b0;
      end
      tick();
      chk("stall_done", {26'd0, c_read_finished, c_write_finished}, 32'b000_010);
      c_write = 3'b000;
      tick();
      chk_idle_outs("stall_after");

      // Round robin: last grant was client 1, so order is 2,0,1,2,0,1
      c_addr = {23'h000222, 23'h000111, 23'h000000};
      c_writedata = {16'h2222, 16'h1111, 16'h0000};
      c_write = 3'b111;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rr_cmd", {31'd0, sdram_write}, 32'd1);
         chk("rr_addr", {9'd0, sdram_addr},
             (rr_exp[k] == 3'b001) ? 32'h0 : (rr_exp[k] == 3'b010) ? 32'h111 : 32'h222);
         tick();
         chk("rr_fin", {29'd0, c_write_finished}, {29'd0, rr_exp[k]});
         tick();
         if (k == 5) c_write = 3'b000;
      end
      tick();
      chk_idle_outs("rr_after");

      // Read and write both set on client 1: read wins
      c_read = 3'b010; c_write = 3'b010; c_addr[45:23] = 23'h123456;
      tick();
      chk("rw_cmd", {30'd0, sdram_write, sdram_read}, 32'b01);
      chk("rw_addr", {9'd0, sdram_addr}, 32'h123456);
      tick();
      sdram_readdatavalid = 1'b1; sdram_readdata = 16'hCAFE;
      tick();
      chk("rw_fin", {26'd0, c_read_finished, c_write_finished}, 32'b010_000);
      chk("rw_data", {16'd0, c_readdata}, 32'hCAFE);
      c_read = 3'b000; c_write = 3'b000; sdram_readdatavalid = 1'b0;
      tick();
      sdram_readdatavalid = 1'b1; sdram_readdata = 16'hDEAD;
      tick();
      sdram_readdatavalid = 1'b0;
      chk("stray_rdv", {16'd0, c_readdata}, 32'hCAFE);
      chk_idle_outs("stray");

      // Reset during WAIT_DATA
      c_read = 3'b100; c_addr[68:46] = 23'h000055;
      tick();
      chk("rst_cmd", {31'd0, sdram_read}, 32'd1);
      tick();
      i_rst = 1'b1; c_read = 3'b000;
      tick();
      i_rst = 1'b0;
      chk_idle_outs("rst_mid");
      chk("rst_mid_addr", {9'd0, sdram_addr}, 32'd0);
      chk("rst_mid_rdata", {16'd0, c_readdata}, 32'd0);
      sdram_readdatavalid = 1'b1; sdram_readdata = 16'hBAD1;
      tick();
      sdram_readdatavalid = 1'b0;
      chk("rst_rdv_ign", {16'd0, c_readdata}, 32'd0);
      chk_idle_outs("rst_rdv");
      c_addr = {23'h000003, 23'h000002, 23'h000001};
      c_write = 3'b011;
      tick();
      chk("rst_next_addr", {9'd0, sdram_addr}, 32'h1);
      tick();
      chk("rst_next_fin", {29'd0, c_write_finished}, 32'b001);
      c_write = 3'b000;
      tick();
      tick();
      chk_idle_outs("end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Three-client arbiter between the audio cores (record, play, mix) and the single Avalon-MM slave port of the SDRAM controller. Each client issues single-word read/write requests with the same request/finished handshake used by the mixing core. The arbiter grants one request at a time in round-robin order, drives the Avalon transaction and returns a one-cycle finished pulse to the granted client. Client 2 is the mixing core; clients 0 and 1 are recorder and player.

## Interface
- No parameters; client count 3, address width 23, data width 16, all fixed.
- Clock and reset are decided: one clock `i_clk`; reset `i_rst` is synchronous and active-high.
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- c_read  in  [2:0]  per-client read request, held until finished
- c_write  in  [2:0]  per-client write request, held until finished
- c_addr  in  [22:0] x3  per-client word address
- c_writedata  in  [15:0] x3  per-client write data
- c_readdata  out  16  shared read-data register, valid on/after c_read_finished
- c_read_finished  out  [2:0]  one-cycle pulse, read complete for that client
- c_write_finished  out  [2:0]  one-cycle pulse, write complete for that client
- sdram_addr  out  23  Avalon address
- sdram_read  out  1  Avalon read
- sdram_write  out  1  Avalon write
- sdram_writedata  out  16  Avalon write data
- sdram_readdata  in  16  Avalon read data
- sdram_waitrequest  in  1  Avalon stall
- sdram_readdatavalid  in  1  Avalon read data valid (pipelined reads)

## Operation
- States: IDLE, ISSUE, WAIT_DATA, DONE.
- Client request = c_read[i] | c_write[i]. Both high on one client: treated as read.
- IDLE: if any request, pick first requesting client searching from (last_grant+1) mod 3 upward; latch index, op, addr, writedata; last_grant <= index; -> ISSUE. No request: stay.
- ISSUE: drive sdram_addr/writedata from latches, assert sdram_read or sdram_write. Command accepted on an edge where it is asserted and sdram_waitrequest=0. Write accepted -> DONE. Read accepted -> WAIT_DATA. Otherwise hold all signals stable.
- WAIT_DATA: on sdram_readdatavalid=1, c_readdata <= sdram_readdata, -> DONE.
- DONE: pulse c_read_finished[g] or c_write_finished[g] (g = granted) for exactly one cycle; -> IDLE.
- Client contract: drop or change its request on the edge where its finished pulse is high. Request changes during grant are ignored (latched values used).
- Only one Avalon command outstanding at any time.
- sdram_readdatavalid outside WAIT_DATA: ignored.
- c_readdata changes only on a completed read; holds otherwise.

## Timing
- Reset values: sdram_read=0, sdram_write=0, sdram_addr=0, sdram_writedata=0, c_readdata=0, all finished=0, state IDLE, last_grant=2 (client 0 first after reset).
- Write, waitrequest low: request seen in IDLE cycle T, command asserted T+1, finished pulse T+2.
- Read, waitrequest low, readdatavalid L cycles after acceptance (L>=1): finished at T+2+L; c_readdata valid from that cycle.
- Each waitrequest-high cycle in ISSUE adds one cycle.
- Minimum spacing between grants: 3 cycles (IDLE, ISSUE, DONE).
- Reset mid-transaction: return to IDLE next cycle, commands deasserted, no finished pulse, pending readdatavalid ignored; round-robin pointer reset.

## Test plan
- Single write: client 2 write addr 0x000010 data 0xBEEF, waitrequest 0 -> sdram_write=1 with those values one cycle, c_write_finished=3'b100 pulse 2 cycles after request.
- Single read, latency 3: client 0 read 0x7FFFFF, readdata 0x1234 -> c_readdata=0x1234 with c_read_finished=3'b001 at T+5.
- Waitrequest stall: hold waitrequest 4 cycles on a write -> sdram_write/addr/data stable 5 cycles, one finished pulse.
- Round robin: all three clients request writes continuously -> grants 0,1,2,0,1,2; no client granted twice while another waits.
- Read+write both set on client 1 -> read issued, only c_read_finished[1] pulses; stray readdatavalid in IDLE leaves c_readdata unchanged.
- Reset asserted in WAIT_DATA -> outputs at reset values next cycle, later readdatavalid ignored, next grant goes to client 0.
